// File: rtl/bpsk_phase_mapper.sv
// BPSK phase mapper: multiplies a signed 8-bit carrier stream by +/-1 per data bit,
// with symbols aligned to carrier periods. Define BPSK_DIFF_EN for differential (DBPSK) encoding.
module bpsk_phase_mapper #(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic signed [7:0] carrier_in,
  input  logic              carrier_valid,
  input  logic              carrier_sof,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic signed [7:0] mod_out,
  output logic              mod_valid,
  output logic              bit_done,
  output logic              busy
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic {
    IDLE,
    SYMBOL
  } state_t;

  state_t            state_q, state_d;
  logic              hold_bit_q, hold_bit_d;
  logic              hold_full_q, hold_full_d;
  logic              inv_q, inv_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic signed [7:0] mod_out_q, mod_out_d;
  logic              mod_valid_q, mod_valid_d;
  logic              bit_done_q, bit_done_d;
  logic              bit_ready_q, bit_ready_d;
  logic              sof_event;
  logic              load;

  // -(-128) does not fit in 8 bits, so it clamps to +127
  function automatic logic signed [7:0] sat_neg(input logic signed [7:0] x);
    return (x == -8'sd128) ? 8'sd127 : -x;
  endfunction

  function automatic logic next_phase(input logic cur, input logic b);
`ifdef BPSK_DIFF_EN
    return cur ^ b;
`else
    return b;
`endif
  endfunction

  assign sof_event = carrier_valid && carrier_sof;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    hold_bit_d  = hold_bit_q;
    hold_full_d = hold_full_q;
    inv_d       = inv_q;
    cyc_cnt_d   = cyc_cnt_q;
    mod_out_d   = mod_out_q;
    mod_valid_d = carrier_valid;
    bit_done_d  = 1'b0;
    load        = 1'b0;

    if (carrier_valid) begin
      unique case (state_q)
        IDLE: begin
          mod_out_d = '0;
          load      = sof_event && hold_full_q;
        end
        SYMBOL: begin
          mod_out_d = inv_q ? sat_neg(carrier_in) : carrier_in;
          if (sof_event) begin
            if (cyc_cnt_q == LAST_CNT) begin
              bit_done_d = 1'b1;
              if (hold_full_q) begin
                load = 1'b1;
              end else begin
                state_d   = IDLE;
                cyc_cnt_d = '0;
                mod_out_d = '0;
              end
            end else begin
              cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // The loading sof sample is already the first sample of the new symbol
      if (load) begin
        inv_d       = next_phase(inv_q, hold_bit_q);
        hold_full_d = 1'b0;
        cyc_cnt_d   = '0;
        state_d     = SYMBOL;
        mod_out_d   = inv_d ? sat_neg(carrier_in) : carrier_in;
      end
    end

    // Accept and load are exclusive: accept needs an empty register, load a full one
    if (bit_valid && bit_ready_q) begin
      hold_full_d = 1'b1;
      hold_bit_d  = bit_in;
    end
    bit_ready_d = !hold_full_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      hold_bit_q  <= 1'b0;
      hold_full_q <= 1'b0;
      inv_q       <= 1'b0;
      cyc_cnt_q   <= '0;
      mod_out_q   <= '0;
      mod_valid_q <= 1'b0;
      bit_done_q  <= 1'b0;
      bit_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_bit_q  <= hold_bit_d;
      hold_full_q <= hold_full_d;
      inv_q       <= inv_d;
      cyc_cnt_q   <= cyc_cnt_d;
      mod_out_q   <= mod_out_d;
      mod_valid_q <= mod_valid_d;
      bit_done_q  <= bit_done_d;
      bit_ready_q <= bit_ready_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign mod_out   = mod_out_q;
  assign mod_valid = mod_valid_q;
  assign bit_done  = bit_done_q;
  assign busy      = (state_q == SYMBOL);

endmodule

// File: tb/tb_bpsk_phase_mapper.sv
// Randomized bench for bpsk_phase_mapper: a 30-sample +/-77 sine carrier with stalls,
// saturation injections and random bit offers, checked against a symbol-level model.
module tb_bpsk_phase_mapper;

  localparam int N_PER  = 4;
  localparam int PERIOD = 30;
  localparam int N_CYC  = 6000;

  logic              Clk = 1'b0;
  logic              Rst;
  logic signed [7:0] carrier_in;
  logic              carrier_valid;
  logic              carrier_sof;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic signed [7:0] mod_out;
  logic              mod_valid;
  logic              bit_done;
  logic              busy;

  bpsk_phase_mapper #(.CYCLES_PER_BIT(N_PER)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .carrier_in   (carrier_in),
    .carrier_valid(carrier_valid),
    .carrier_sof  (carrier_sof),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .mod_out      (mod_out),
    .mod_valid    (mod_valid),
    .bit_done     (bit_done),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: symbol-level view (queue of at most one waiting bit,
  // phase sign, number of carrier periods started in the current symbol).
  bit  m_in_symbol;
  int  m_periods;
  int  m_sign;        // +1 in-phase, -1 inverted
  bit  m_waiting[$];
  int  e_mod, e_mval, e_done, e_ready, e_busy;
  int  sine[PERIOD];
  int  k;

  function automatic int apply_sign(input int x, input int s);
    int r;
    r = x * s;
    return (r > 127) ? 127 : r;
  endfunction

  function automatic int new_sign(input int cur, input bit b);
`ifdef BPSK_DIFF_EN
    return b ? -cur : cur;
`else
    return b ? -1 : 1;
`endif
  endfunction

  task automatic start_symbol(input int x);
    m_sign      = new_sign(m_sign, m_waiting.pop_front());
    m_in_symbol = 1'b1;
    m_periods   = 1;
    e_mod       = apply_sign(x, m_sign);
  endtask

  // Predict outputs after the next rising edge from the inputs currently driven
  task automatic model_step();
    bit accept;
    int x;
    accept = bit_valid && (m_waiting.size() == 0);
    x      = int'(carrier_in);
    if (Rst) begin
      m_in_symbol = 1'b0;
      m_periods   = 0;
      m_sign      = 1;
      m_waiting.delete();
      e_mod = 0; e_mval = 0; e_done = 0; e_ready = 1; e_busy = 0;
      return;
    end
    e_done = 0;
    if (carrier_valid) begin
      if (!m_in_symbol) begin
        if (carrier_sof && m_waiting.size() != 0) start_symbol(x);
        else e_mod = 0;
      end else if (carrier_sof && m_periods == N_PER) begin
        e_done = 1;
        if (m_waiting.size() != 0) begin
          start_symbol(x);
        end else begin
          m_in_symbol = 1'b0;
          e_mod = 0;
        end
      end else begin
        if (carrier_sof) m_periods++;
        e_mod = apply_sign(x, m_sign);
      end
    end
    if (accept) m_waiting.push_back(bit_in);
    e_mval  = carrier_valid;
    e_ready = (m_waiting.size() == 0);
    e_busy  = m_in_symbol;
  endtask

  task automatic compare_all();
    check("mod_out",   int'(mod_out), e_mod);
    check("mod_valid", int'(mod_valid), e_mval);
    check("bit_done",  int'(bit_done), e_done);
    check("bit_ready", int'(bit_ready), e_ready);
    check("busy",      int'(busy), e_busy);
  endtask

  // Drive one carrier sample (or a stall) and advance the carrier phase
  task automatic drive_carrier(input bit stall, input bit inject);
    carrier_valid = !stall;
    if (stall) begin
      carrier_sof = 1'($urandom_range(0, 1));
      carrier_in  = 8'($urandom);
    end else begin
      carrier_sof = (k == 0);
      if (inject) carrier_in = ($urandom_range(0, 1) != 0) ? -8'sd128 : 8'sd127;
      else        carrier_in = 8'(sine[k]);
      k = (k + 1) % PERIOD;
    end
  endtask

  initial begin
    for (int i = 0; i < PERIOD; i++)
      sine[i] = int'(77.0 * $sin(2.0 * 3.14159265358979 * i / PERIOD));
    check("sine_s1", sine[1], 16);
    check("sine_s22", sine[22], -77);

    k = 0;
    Rst = 1'b1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    drive_carrier(1'b0, 1'b0);
    model_step();

    // Reset held, then a free-running carrier with no bits offered
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      compare_all();
      Rst = (c < 3);
      drive_carrier(1'b0, 1'b0);
      model_step();
    end

    for (int c = 0; c < N_CYC; c++) begin
      @(negedge Clk);
      compare_all();
      Rst = (c == 3000) || ($urandom_range(0, 1499) == 0);
      bit_valid = ($urandom_range(0, 3) == 0);
      bit_in    = 1'($urandom_range(0, 1));
      drive_carrier($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      model_step();
    end

    @(negedge Clk);
    compare_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpsk_phase_mapper.md
# bpsk_phase_mapper

BPSK modulation stage directly downstream of the carrier sine generator. Accepts data bits over a valid/ready handshake and multiplies the incoming 8-bit signed carrier stream by ±1 per bit. Each symbol spans a whole number of carrier periods and starts on a carrier period boundary. Drives the modulated sample stream to the DAC/output stage.

## Interface
- `CYCLES_PER_BIT`, default 4: carrier periods per symbol; must be ≥1.
- `Clk`  input  1  clock; all logic on its rising edge.
- `Rst`  input  1  synchronous, active-high reset.
- `carrier_in`  input  8  signed two's-complement carrier sample.
- `carrier_valid`  input  1  `carrier_in` is valid this cycle; tie high for one sample per clock.
- `carrier_sof`  input  1  `carrier_in` is sample 0 of a carrier period; ignored unless `carrier_valid` is high.
- `bit_in`  input  1  data bit.
- `bit_valid`  input  1  `bit_in` is offered.
- `bit_ready`  output  1  holding register is empty; a bit transfers when `bit_valid && bit_ready`.
- `mod_out`  output  8  signed modulated sample.
- `mod_valid`  output  1  `mod_out` is valid; equals `carrier_valid` delayed by one cycle.
- `bit_done`  output  1  one-cycle pulse when a symbol completes.
- `busy`  output  1  high while in SYMBOL.

## Operation
- Storage:
  - one-entry bit holding register (`hold_bit`, `hold_full`);
  - current symbol phase `inv` (1 = inverted);
  - period counter `cyc_cnt`, width max(1, $clog2(CYCLES_PER_BIT));
  - state register.
- `bit_ready` is registered and equals `!hold_full`. An accepted bit sets `hold_full`.
- An accept and a consume cannot occur in the same cycle, because `bit_ready` is low while `hold_full` is set.
- Sample qualifier: "sof event" = `carrier_valid && carrier_sof`.
- State IDLE:
  - outputs zero samples;
  - on a sof event with `hold_full` set: load the symbol (`inv` from `hold_bit`), clear `hold_full`, set `cyc_cnt` to 0, go to SYMBOL;
  - the sof sample itself is modulated as the first sample of the new symbol.
- State SYMBOL, on every valid sample: output `inv ? sat_neg(carrier_in) : carrier_in`.
- State SYMBOL, on a sof event (not the symbol's own starting sample):
  - if `cyc_cnt == CYCLES_PER_BIT-1`: the symbol ends and `bit_done` pulses.
    - If `hold_full` is set: load the next symbol on this sample with no gap, and stay in SYMBOL.
    - Otherwise: go to IDLE, and this sample outputs 0.
  - else: `cyc_cnt` increments.
- When `CYCLES_PER_BIT=1`, every subsequent sof ends the symbol.
- Negation rule: `sat_neg(x) = -x`, except `sat_neg(-128) = +127`. The result stays 8-bit signed; there is no width growth.
- `carrier_valid` low: all state freezes; `mod_valid` goes low one cycle later and `mod_out` holds its last value.
- Symbols are counted only in carrier periods, so a stalled carrier stretches the symbol.
- Absolute mapping (default): bit 0 → in-phase, bit 1 → inverted.

## Timing
- Latency: `carrier_in` at cycle t appears on `mod_out` at t+1. `bit_done` is asserted in the same cycle as the first `mod_out` sample of the next symbol (or of idle).
- Reset values:
  - `mod_out` = 0, `mod_valid` = 0, `bit_ready` = 1, `bit_done` = 0, `busy` = 0;
  - state IDLE, `hold_full` = 0, `inv` = 0, `cyc_cnt` = 0.
- Reset mid-symbol aborts the symbol and discards the held bit. The cycle after reset deasserts, `mod_out` is 0 and `bit_done` stays 0.
- For gapless back-to-back symbols, the next bit must be accepted at least one cycle before the ending sof event.
- A bit accepted on the same cycle as a sof event in IDLE is not used until the next sof event.

## Configuration
- `BPSK_DIFF_EN` defined: differential encoding (DBPSK).
  - At each symbol load, `inv <= inv ^ bit`.
  - The reference phase persists across IDLE gaps and clears only on `Rst`.
- `BPSK_DIFF_EN` undefined: absolute mapping, `inv <= bit`.

## Test plan
- Reset with a 30-sample ±77 carrier running and no bits: `mod_out` stays 0, `bit_ready` = 1, `busy` = 0, `bit_done` never pulses.
- Bit 0 accepted mid-period, `CYCLES_PER_BIT=4`:
  - outputs are zero until the next sof;
  - then 120 samples equal the carrier (0, 16, 31 … −16), each one cycle late;
  - `bit_done` pulses at the 4th following sof;
  - output then returns to 0.
- Bits 1 then 0 offered back to back:
  - first 120 samples are negated (sample 1 = −16 = 8'hF0, sample 7 = −77);
  - the next 120 are in-phase with no zero gap;
  - `bit_ready` drops for exactly the time `hold_full` is set.
- Saturation: `carrier_in` = −128 during a bit-1 symbol → `mod_out` = +127; `carrier_in` = +127 → −127.
- Stall and reset:
  - `carrier_valid` low for 5 cycles mid-symbol → `mod_valid` low for 5 cycles, and the symbol still spans 120 valid samples;
  - `Rst` at sample 50 → `mod_out` = 0 next cycle and the held bit is discarded.
- With `BPSK_DIFF_EN`: bits 1, 1, 0 → phases inverted, in-phase, in-phase. Without it, the same bits give inverted, inverted, in-phase.
